inst_cache: RTL and testbench
=============================

INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter INDEX_BITS, default 6, meaning log2 of line count (64 lines).
REQ-002 Parameter OFFSET_BITS, default 2, meaning log2 of words per line (4 words, 16 bytes).
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port cpu_pc  input  32  fetch address from the fetch stage, word aligned.
REQ-006 Port cpu_req  input  1  fetch request valid.
REQ-007 Port cpu_instruction  output  32  instruction word for cpu_pc; valid when cpu_req=1 and cpu_stall=0.
REQ-008 Port cpu_stall  output  1  fetch must hold its PC and pipeline registers.
REQ-009 Port flush  input  1  invalidates every line.
REQ-010 Port mem_req  output  1  refill word request to backing instruction memory.
REQ-011 Port mem_addr  output  32  word address of the requested refill word.
REQ-012 Port mem_ack  input  1  mem_rdata is valid this cycle.
REQ-013 Port mem_rdata  input  32  refill data word.
REQ-014 Port hit_count  output  32  count of cycles with a hit (cpu_req=1, cpu_stall=0).
REQ-015 Port miss_count  output  32  count of refills started.

Function
REQ-016 Address split: offset = cpu_pc[OFFSET_BITS+1:2], index = the next INDEX_BITS bits, tag = the remaining upper bits (22 bits at defaults).
REQ-017 Organisation: direct-mapped; per-line valid bit, tag and data words.
REQ-018 Hit condition: state IDLE, cpu_req=1, valid[index]=1, tag match.
REQ-019 Hit timing: cpu_instruction is combinational from the data array in the same cycle; cpu_stall=0.
REQ-020 cpu_stall = 1 when state is REFILL, or when state is IDLE with cpu_req=1 and no hit.
REQ-021 When cpu_req=0, cpu_stall=0 and cpu_instruction=0.
REQ-022 FSM states: IDLE and REFILL.
REQ-023 IDLE->REFILL on a miss: latch tag/index into refill registers; clear word counter; miss_count +1.
REQ-024 In REFILL, mem_req=1 and mem_addr = {latched tag, latched index, counter, 2'b00}.
REQ-025 Each mem_ack in REFILL writes mem_rdata into data[latched index][counter] and increments the counter.
REQ-026 REFILL->IDLE on the ack with counter = 2^OFFSET_BITS-1; same edge writes tag and sets valid.
REQ-027 Minimum miss penalty at defaults (ack every cycle): 5 stall cycles; the hit is in the 6th cycle.
REQ-028 mem_req stays asserted between acks; a memory with variable latency is supported (no timeout).
REQ-029 In REFILL, changes on cpu_pc or cpu_req are ignored. On return to IDLE, lookup uses the current cpu_pc.
REQ-030 In IDLE, mem_req=0 and mem_addr=0.
REQ-031 flush=1 clears all valid bits on the next edge, with priority over a same-cycle valid set.
REQ-032 flush during REFILL aborts the refill: state becomes IDLE, the line is not validated, and any same-cycle ack is discarded.
REQ-033 flush in IDLE forces cpu_stall=1 that cycle (no hit reported).
REQ-034 Counters wrap modulo 2^32; they are not cleared by flush.

Reset
REQ-035 When rst=0 at a clock edge: state IDLE, all valid bits 0, counter 0, hit_count 0, miss_count 0.
REQ-036 Outputs after reset: mem_req=0, mem_addr=0, cpu_stall=0 while cpu_req=0.
REQ-037 Reset during REFILL abandons the refill; a later mem_ack is ignored while in IDLE.
REQ-038 Data and tag arrays are not reset.

Structure
REQ-039 Shared package holds the state encoding (IDLE=0, REFILL=1) and the default INDEX_BITS and OFFSET_BITS values.
REQ-040 One sub-module, icache_array, holds valid/tag/data storage with a combinational read and a synchronous write/invalidate; inst_cache holds the FSM and counters.
REQ-041 Integration: inst_cache sits between the fetch stage's pc/instruction ports and instruction memory; cpu_stall is ORed into the pipeline stall.

Verification
REQ-042 Cold miss: after reset, cpu_req=1, cpu_pc=0x0000_0040, ack every cycle, mem returns 0xA0..0xA3. Required: mem_addr 0x40, 0x44, 0x48, 0x4C; 5 stall cycles; then instruction=0xA0; miss_count=1.
REQ-043 Line hits: following REQ-042, step cpu_pc through 0x44, 0x48, 0x4C. Required: instructions 0xA1, 0xA2, 0xA3 with no stall; hit_count=4.
REQ-044 Conflict miss: access 0x0000_0440 (same index, different tag). Required: a refill from 0x440; then access 0x40. Required: a second refill; miss_count=3.
REQ-045 Flush mid-refill: assert flush after the 2nd ack. Required: IDLE next cycle, mem_req=0, line invalid; re-access causes a new 4-word refill.
REQ-046 Slow memory plus reset: ack every 3rd cycle. Required: mem_req held and mem_addr stable between acks. Then rst=0 mid-refill. Required: mem_req=0 and counters 0 next cycle; a stray ack causes no write.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache.
// Holds the FSM state encoding and the default geometry (64 lines of 4 words).
package inst_cache_pkg;

    localparam int unsigned DefIndexBits  = 6;
    localparam int unsigned DefOffsetBits = 2;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StRefill = 1'b1
    } state_e;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and refill-side bus of the instruction cache.
//   cpu_pc, cpu_req, flush     : fetch stage -> cache
//   cpu_instruction, cpu_stall : cache -> fetch stage
//   mem_req, mem_addr          : cache -> instruction memory
//   mem_ack, mem_rdata         : instruction memory -> cache
// master: the environment (fetch stage plus memory); slave: the cache.
interface inst_cache_if;

    logic [31:0] cpu_pc;
    logic        cpu_req;
    logic [31:0] cpu_instruction;
    logic        cpu_stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_pc, cpu_req, flush, mem_ack, mem_rdata,
        input  cpu_instruction, cpu_stall, mem_req, mem_addr
    );

    modport slave (
        input  cpu_pc, cpu_req, flush, mem_ack, mem_rdata,
        output cpu_instruction, cpu_stall, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage of the direct-mapped instruction cache.
//   clk_i, rst_ni         : clock; synchronous active-low reset (clears valid bits only)
//   rd_index_i/offset_i   : combinational lookup -> rd_valid_o, rd_tag_o, rd_data_o
//   wr_en_i               : write wr_data_i into data[wr_index_i][wr_offset_i]
//   validate_i            : write wr_tag_i and set valid[wr_index_i]
//   inv_all_i             : clear every valid bit; wins over a same-cycle validate
module icache_array #(
    parameter int unsigned IndexBits  = 6,
    parameter int unsigned OffsetBits = 2,
    parameter int unsigned TagBits    = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IndexBits-1:0]  rd_index_i,
    input  logic [OffsetBits-1:0] rd_offset_i,
    output logic                  rd_valid_o,
    output logic [TagBits-1:0]    rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  wr_en_i,
    input  logic [IndexBits-1:0]  wr_index_i,
    input  logic [OffsetBits-1:0] wr_offset_i,
    input  logic [31:0]           wr_data_i,
    input  logic                  validate_i,
    input  logic [TagBits-1:0]    wr_tag_i,
    input  logic                  inv_all_i
);

    localparam int unsigned Lines = 2 ** IndexBits;
    localparam int unsigned Words = 2 ** OffsetBits;

    logic [Lines-1:0]   valid_q;
    logic [TagBits-1:0] tag_q  [Lines];
    logic [31:0]        data_q [Lines][Words];

    always_ff @(posedge clk_i) begin
        if (!rst_ni || inv_all_i) begin
            valid_q <= '0;
        end else if (validate_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data contents are don't-care until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_index_i][wr_offset_i] <= wr_data_i;
        end
        if (validate_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between the fetch stage and instruction memory.
//   clk, rst             : clock; synchronous active-low reset
//   bus (slave)          : fetch request/response, flush and word-by-word refill bus
//   hit_count            : cycles with cpu_req=1 and cpu_stall=0 (wraps)
//   miss_count           : refills started (wraps)
// Hits return data combinationally; a miss stalls fetch while the whole line is
// refilled one word per mem_ack, then the lookup is retried with the current PC.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = DefIndexBits,
    parameter int unsigned OFFSET_BITS = DefOffsetBits
) (
    input  logic        clk,
    input  logic        rst,
    inst_cache_if.slave bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned TagBits = 32 - INDEX_BITS - OFFSET_BITS - 2;
    localparam logic [OFFSET_BITS-1:0] LastWord = '1;

    logic [OFFSET_BITS-1:0] pc_offset;
    logic [INDEX_BITS-1:0]  pc_index;
    logic [TagBits-1:0]     pc_tag;
    logic                   unused_pc_bits;

    assign pc_offset      = bus.cpu_pc[OFFSET_BITS+1:2];
    assign pc_index       = bus.cpu_pc[OFFSET_BITS+2 +: INDEX_BITS];
    assign pc_tag         = bus.cpu_pc[31 -: TagBits];
    assign unused_pc_bits = ^bus.cpu_pc[1:0];

    state_e                 state_q, state_d;
    logic [TagBits-1:0]     refill_tag_q, refill_tag_d;
    logic [INDEX_BITS-1:0]  refill_index_q, refill_index_d;
    logic [OFFSET_BITS-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]            hit_count_q, hit_count_d;
    logic [31:0]            miss_count_q, miss_count_d;

    logic               rd_valid;
    logic [TagBits-1:0] rd_tag;
    logic [31:0]        rd_data;
    logic               hit;
    logic               data_we;
    logic               line_validate;
    logic               stall;
    logic               mem_req;
    logic [31:0]        mem_addr;

    icache_array #(
        .IndexBits  (INDEX_BITS),
        .OffsetBits (OFFSET_BITS),
        .TagBits    (TagBits)
    ) u_array (
        .clk_i       (clk),
        .rst_ni      (rst),
        .rd_index_i  (pc_index),
        .rd_offset_i (pc_offset),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_en_i     (data_we),
        .wr_index_i  (refill_index_q),
        .wr_offset_i (word_cnt_q),
        .wr_data_i   (bus.mem_rdata),
        .validate_i  (line_validate),
        .wr_tag_i    (refill_tag_q),
        .inv_all_i   (bus.flush)
    );

    // A flush cycle never reports a hit: the lines are being invalidated.
    assign hit = (state_q == StIdle) && bus.cpu_req && rd_valid && (rd_tag == pc_tag) &&
                 !bus.flush;

    always_comb begin
        state_d        = state_q;
        refill_tag_d   = refill_tag_q;
        refill_index_d = refill_index_q;
        word_cnt_d     = word_cnt_q;
        miss_count_d   = miss_count_q;
        hit_count_d    = hit ? hit_count_q + 32'd1 : hit_count_q;
        data_we        = 1'b0;
        line_validate  = 1'b0;
        stall          = 1'b0;
        mem_req        = 1'b0;
        mem_addr       = '0;

        unique case (state_q)
            StIdle: begin
                stall = bus.cpu_req && !hit;
                // Refill is not started on a flush cycle; the lookup retries next cycle.
                if (bus.cpu_req && !hit && !bus.flush) begin
                    state_d        = StRefill;
                    refill_tag_d   = pc_tag;
                    refill_index_d = pc_index;
                    word_cnt_d     = '0;
                    miss_count_d   = miss_count_q + 32'd1;
                end
            end
            StRefill: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {refill_tag_q, refill_index_q, word_cnt_q, 2'b00};
                if (bus.flush) begin
                    // Abort: same-cycle ack is dropped and the line stays invalid.
                    state_d = StIdle;
                end else if (bus.mem_ack) begin
                    data_we    = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == LastWord) begin
                        line_validate = 1'b1;
                        state_d       = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            refill_tag_q   <= '0;
            refill_index_q <= '0;
            word_cnt_q     <= '0;
            hit_count_q    <= '0;
            miss_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            refill_tag_q   <= refill_tag_d;
            refill_index_q <= refill_index_d;
            word_cnt_q     <= word_cnt_d;
            hit_count_q    <= hit_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

    assign bus.cpu_stall       = stall;
    assign bus.cpu_instruction = hit ? rd_data : '0;
    assign bus.mem_req         = mem_req;
    assign bus.mem_addr        = mem_addr;
    assign hit_count           = hit_count_q;
    assign miss_count          = miss_count_q;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a per-cycle vector table for the cold miss and
// line hits, then hand-written sequences for conflict misses, flush and reset.
module tb_inst_cache;

    logic        clk;
    logic        rst;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    int          n_tests;
    int          n_fail;

    inst_cache_if bus ();

    inst_cache #(
        .INDEX_BITS  (6),
        .OFFSET_BITS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_stall;
        logic        exp_mreq;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Miss at pc, then up to nwords refill words with gap idle cycles before
    // each ack; a complete refill ends with the hit cycle checked.
    task automatic run_miss(input logic [31:0] pc, input logic [31:0] dbase,
                            input int gap, input int nwords);
        logic [31:0] base;
        base          = {pc[31:4], 4'h0};
        bus.cpu_req   = 1'b1;
        bus.cpu_pc    = pc;
        bus.mem_ack   = 1'b0;
        bus.flush     = 1'b0;
        @(negedge clk);
        chk($sformatf("miss %h stall", pc), bus.cpu_stall, 1);
        chk($sformatf("miss %h idle mem_req", pc), bus.mem_req, 0);
        step();
        for (int w = 0; w < nwords; w++) begin
            for (int g = 0; g < gap; g++) begin
                bus.mem_ack = 1'b0;
                @(negedge clk);
                chk($sformatf("wait %h w%0d mem_req", pc, w), bus.mem_req, 1);
                chk($sformatf("wait %h w%0d addr", pc, w), bus.mem_addr, base + 32'(4 * w));
                chk($sformatf("wait %h w%0d stall", pc, w), bus.cpu_stall, 1);
                step();
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = dbase + 32'(w);
            @(negedge clk);
            chk($sformatf("ack %h w%0d addr", pc, w), bus.mem_addr, base + 32'(4 * w));
            chk($sformatf("ack %h w%0d stall", pc, w), bus.cpu_stall, 1);
            step();
        end
        bus.mem_ack = 1'b0;
        if (nwords == 4) begin
            @(negedge clk);
            chk($sformatf("hit %h stall", pc), bus.cpu_stall, 0);
            chk($sformatf("hit %h mem_req", pc), bus.mem_req, 0);
            chk($sformatf("hit %h instr", pc), bus.cpu_instruction, dbase + 32'(pc[3:2]));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.cpu_pc    = '0;
        bus.cpu_req   = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        // Cold miss at 0x40 with ack every cycle, then hits across the line.
        vecs[0] = '{1'b1, 32'h40, 1'b0, 32'h0,  1'b1, 1'b0, 32'h00, 32'h0};
        vecs[1] = '{1'b1, 32'h40, 1'b1, 32'hA0, 1'b1, 1'b1, 32'h40, 32'h0};
        vecs[2] = '{1'b1, 32'h40, 1'b1, 32'hA1, 1'b1, 1'b1, 32'h44, 32'h0};
        vecs[3] = '{1'b1, 32'h40, 1'b1, 32'hA2, 1'b1, 1'b1, 32'h48, 32'h0};
        vecs[4] = '{1'b1, 32'h40, 1'b1, 32'hA3, 1'b1, 1'b1, 32'h4C, 32'h0};
        vecs[5] = '{1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 32'hA0};
        vecs[6] = '{1'b1, 32'h44, 1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 32'hA1};
        vecs[7] = '{1'b1, 32'h48, 1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 32'hA2};
        vecs[8] = '{1'b1, 32'h4C, 1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 32'hA3};
        vecs[9] = '{1'b0, 32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 32'h0};

        repeat (2) step();
        rst = 1'b1;
        @(negedge clk);
        chk("reset mem_req", bus.mem_req, 0);
        chk("reset mem_addr", bus.mem_addr, 0);
        chk("reset stall", bus.cpu_stall, 0);
        chk("reset instr", bus.cpu_instruction, 0);
        chk("reset hit_count", hit_count, 0);
        chk("reset miss_count", miss_count, 0);
        step();

        for (int i = 0; i < 10; i++) begin
            bus.cpu_req   = vecs[i].req;
            bus.cpu_pc    = vecs[i].pc;
            bus.mem_ack   = vecs[i].ack;
            bus.mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("vec%0d stall", i), bus.cpu_stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d mem_req", i), bus.mem_req, vecs[i].exp_mreq);
            chk($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d instr", i), bus.cpu_instruction, vecs[i].exp_instr);
            step();
        end
        chk("cold hit_count", hit_count, 4);
        chk("cold miss_count", miss_count, 1);

        // Conflict misses on index 4: 0x440 evicts 0x40, then 0x40 evicts 0x440.
        run_miss(32'h440, 32'hB0, 0, 4);
        run_miss(32'h040, 32'hC0, 0, 4);
        chk("conflict miss_count", miss_count, 3);
        chk("conflict hit_count", hit_count, 6);

        // Flush after the 2nd ack: refill aborts, line stays invalid.
        run_miss(32'h80, 32'hBAD0, 0, 2);
        bus.flush     = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("flush cycle mem_req", bus.mem_req, 1);
        chk("flush cycle addr", bus.mem_addr, 32'h88);
        step();
        bus.flush   = 1'b0;
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("after flush mem_req", bus.mem_req, 0);
        chk("after flush addr", bus.mem_addr, 0);
        chk("after flush stall", bus.cpu_stall, 0);
        step();
        run_miss(32'h040, 32'hE0, 0, 4);
        run_miss(32'h084, 32'hD0, 0, 4);
        chk("flush miss_count", miss_count, 6);
        chk("flush hit_count", hit_count, 8);

        // Flush in IDLE on a resident line: no hit reported.
        bus.cpu_req = 1'b1;
        bus.cpu_pc  = 32'h84;
        bus.flush   = 1'b1;
        @(negedge clk);
        chk("idle flush stall", bus.cpu_stall, 1);
        chk("idle flush instr", bus.cpu_instruction, 0);
        step();
        bus.flush   = 1'b0;
        bus.cpu_req = 1'b0;
        step();
        chk("idle flush hit_count", hit_count, 8);

        // Slow memory, then reset mid-refill and a stray ack.
        run_miss(32'hC0, 32'h5A0, 2, 2);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("slow hold addr", bus.mem_addr, 32'hC8);
        chk("slow hold mem_req", bus.mem_req, 1);
        step();
        rst = 1'b0;
        step();
        rst         = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("rst mid mem_req", bus.mem_req, 0);
        chk("rst mid addr", bus.mem_addr, 0);
        chk("rst mid stall", bus.cpu_stall, 0);
        chk("rst mid hit_count", hit_count, 0);
        chk("rst mid miss_count", miss_count, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_0BAD;
        step();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("stray ack mem_req", bus.mem_req, 0);
        chk("stray ack miss_count", miss_count, 0);
        step();
        run_miss(32'hC0, 32'hF0, 2, 4);
        chk("post-reset hit_count", hit_count, 1);
        chk("post-reset miss_count", miss_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
